// File: rtl/mdu_seq_ctrl_pkg.sv
// ============================================================================
// Module : mdu_seq_ctrl_pkg
// Brief  : Shared codes for the RV32M sequencer: funct3 ops, ALU ops, states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_seq_ctrl_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NEG_A   = 3'd1,
    ST_NEG_B   = 3'd2,
    ST_ITER    = 3'd3,
    ST_FIX_INV = 3'd4,
    ST_FIX_INC = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Smallest counter width that can hold XLEN.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_special_detect.sv
// ============================================================================
// Module : mdu_special_detect
// Brief  : Operand sign flags plus divide-by-zero / signed-overflow shortcut.
//          Divide handling present only when MDU_DIV_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_special_detect
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            neg_a,
  output logic            neg_b,
  output logic            special,
  output logic [XLEN-1:0] special_val
);

  logic signed_a;
  logic signed_b;

  // MULHSU treats B as unsigned; MUL low word is sign-agnostic.
  assign signed_a = funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign signed_b = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  assign neg_a    = signed_a && rs1[XLEN-1];
  assign neg_b    = signed_b && rs2[XLEN-1];

`ifdef MDU_DIV_EN
  logic div_zero;
  logic overflow;

  assign div_zero = funct3[2] && (rs2 == '0);
  assign overflow = funct3[2] && !funct3[0] &&
                    (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

  always_comb begin
    special     = div_zero || overflow;
    special_val = '0;
    if (div_zero) begin
      special_val = funct3[1] ? rs1 : '1;
    end else if (overflow) begin
      special_val = funct3[1] ? '0 : rs1;
    end
  end
`else
  logic unused_bits;

  assign special     = funct3[2];
  assign special_val = '0;
  assign unused_bits = ^{rs1[XLEN-2:0], rs2[XLEN-2:0]};
`endif

endmodule

`default_nettype wire

// File: rtl/mdu_seq_ctrl.sv
// ============================================================================
// Module : mdu_seq_ctrl
// Brief  : Iterative RV32M multiply/divide sequencer driving the shared ALU.
//          Divide ops are supported only when MDU_DIV_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = cnt_width(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_sel,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_funct,
  input  logic [XLEN-1:0] alu_out
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   w_q, w_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              det_neg_a;
  logic              det_neg_b;
  logic              det_special;
  logic [XLEN-1:0]   det_special_val;
  logic [XLEN-1:0]   fix_word;
  logic              fix_sign;
  logic              fix_inc;

  mdu_special_detect #(.XLEN(XLEN)) u_special_detect (
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .neg_a       (det_neg_a),
    .neg_b       (det_neg_b),
    .special     (det_special),
    .special_val (det_special_val)
  );

  // Divide keeps remainder in hi and quotient in lo.
  assign fix_word = op_q[2] ? (op_q[1] ? hi_q : lo_q)
                            : ((op_q == F3_MUL) ? lo_q : hi_q);
  assign fix_sign = (op_q[2] && op_q[1]) ? neg_a_q : (neg_a_q ^ neg_b_q);
  assign fix_inc  = (op_q == F3_MULH || op_q == F3_MULHSU) ? (lo_q == '0) : 1'b1;

`ifdef MDU_DIV_EN
  logic [XLEN-1:0] r_shift;
  assign r_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
`endif

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

  always_comb begin
    alu_sel   = 1'b0;
    alu_in1   = '0;
    alu_in2   = '0;
    alu_funct = ALU_ADD;
    case (state_q)
      ST_NEG_A: begin
        alu_sel   = 1'b1;
        alu_in2   = a_q;
        alu_funct = ALU_SUB;
      end
      ST_NEG_B: begin
        alu_sel   = 1'b1;
        alu_in2   = b_q;
        alu_funct = ALU_SUB;
      end
      ST_ITER: begin
        alu_sel = 1'b1;
        alu_in1 = hi_q;
        alu_in2 = a_q;
`ifdef MDU_DIV_EN
        if (op_q[2]) begin
          alu_in1   = r_shift;
          alu_in2   = b_q;
          alu_funct = ALU_SUB;
        end
`endif
      end
      ST_FIX_INV: begin
        alu_sel   = 1'b1;
        alu_in1   = fix_word;
        alu_in2   = '1;
        alu_funct = ALU_XOR;
      end
      ST_FIX_INC: begin
        alu_sel = 1'b1;
        alu_in1 = w_q;
        alu_in2 = {{(XLEN-1){1'b0}}, fix_inc};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    w_d      = w_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = funct3;
          a_d     = rs1;
          b_d     = rs2;
          neg_a_d = det_neg_a;
          neg_b_d = det_neg_b;
          cnt_d   = '0;
          if (det_special) begin
            result_d = det_special_val;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_NEG_A;
          end
        end
      end
      ST_NEG_A: begin
        if (neg_a_q) a_d = alu_out;
        state_d = ST_NEG_B;
      end
      ST_NEG_B: begin
        b_d     = neg_b_q ? alu_out : b_q;
        hi_d    = '0;
        lo_d    = op_q[2] ? a_q : b_d;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (lo_q[0]) begin
          {hi_d, lo_d} = {(alu_out < hi_q), alu_out, lo_q[XLEN-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
        end
`ifdef MDU_DIV_EN
        if (op_q[2]) begin
          if (hi_q[XLEN-1] || (r_shift >= b_q)) begin
            hi_d = alu_out;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = r_shift;
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIX_INV;
      end
      ST_FIX_INV: begin
        w_d     = fix_sign ? alu_out : fix_word;
        state_d = ST_FIX_INC;
      end
      ST_FIX_INC: begin
        result_d = fix_sign ? alu_out : w_q;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      w_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      w_q      <= w_d;
      result_q <= result_d;
    end
  end

endmodule

`default_nettype wire
